// File: rtl/signed_divider_seq_if.sv
// rtl/signed_divider_seq_if.sv - operand, control and result bundle for the sequential signed divider
interface signed_divider_seq_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] sw;
    logic             load_b;
    logic             clear;
    logic             run;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic [WIDTH-1:0] bval;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic             ovf;

    modport master (
        output sw, load_b, clear, run,
        input  quotient, remainder, bval, busy, done, div_zero, ovf
    );

    modport slave (
        input  sw, load_b, clear, run,
        output quotient, remainder, bval, busy, done, div_zero, ovf
    );
endinterface

// File: rtl/signed_divider_seq.sv
// rtl/signed_divider_seq.sv - sequential signed restoring divider, one quotient bit per cycle
module signed_divider_seq #(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    signed_divider_seq_if.slave   bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_FIX, S_DONE} state_t;
    state_t state, state_n;

    logic [CW-1:0]    count;
    logic [WIDTH-1:0] dividend, b_r, abs_b, a, p;
    logic [WIDTH-1:0] q_r, r_r;
    logic             qneg, rneg, dz_r, ovf_r, busy_r, done_r;

    logic [WIDTH-1:0] abs_dvd, abs_bv;
    logic [WIDTH:0]   p_sh, t;
    logic [WIDTH-1:0] a_sh;
    logic             b_zero, is_ovf;

    // Magnitudes are taken as unsigned, so MIN maps to 2^(WIDTH-1) without overflow.
    always_comb begin
        abs_dvd = dividend[WIDTH-1] ? -dividend : dividend;
        abs_bv  = b_r[WIDTH-1] ? -b_r : b_r;
        b_zero  = (b_r == '0);
        is_ovf  = (dividend == MIN_VAL) && (b_r == '1);
        p_sh    = {p, a[WIDTH-1]};
        a_sh    = {a[WIDTH-2:0], 1'b0};
        t       = p_sh - {1'b0, abs_b};
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: if (bus.run) state_n = S_PREP;
            S_PREP: state_n = (b_zero || is_ovf) ? S_DONE : S_ITER;
            S_ITER: if (count == CW'(WIDTH - 1)) state_n = S_FIX;
            S_FIX:  state_n = S_DONE;
            S_DONE: if (!bus.run) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count    <= '0;
            dividend <= '0;
            b_r      <= '0;
            abs_b    <= '0;
            a        <= '0;
            p        <= '0;
            q_r      <= '0;
            r_r      <= '0;
            qneg     <= 1'b0;
            rneg     <= 1'b0;
            dz_r     <= 1'b0;
            ovf_r    <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            busy_r <= (state_n == S_PREP) || (state_n == S_ITER) || (state_n == S_FIX);
            done_r <= (state_n == S_DONE);
            case (state)
                S_IDLE, S_DONE: begin
                    if (bus.load_b) b_r <= bus.sw;
                    if (bus.clear) begin
                        q_r   <= '0;
                        r_r   <= '0;
                        dz_r  <= 1'b0;
                        ovf_r <= 1'b0;
                    end
                    if (state == S_IDLE && bus.run) dividend <= bus.sw;
                end
                S_PREP: begin
                    qneg  <= dividend[WIDTH-1] ^ b_r[WIDTH-1];
                    rneg  <= dividend[WIDTH-1];
                    abs_b <= abs_bv;
                    a     <= abs_dvd;
                    p     <= '0;
                    count <= '0;
                    dz_r  <= b_zero;
                    ovf_r <= !b_zero && is_ovf;
                    if (b_zero) begin
                        q_r <= '0;
                        r_r <= dividend;
                    end else if (is_ovf) begin
                        q_r <= MIN_VAL;
                        r_r <= '0;
                    end
                end
                S_ITER: begin
                    // Partial remainder stays below |B|, so WIDTH bits hold it between steps.
                    if (!t[WIDTH]) begin
                        p <= t[WIDTH-1:0];
                        a <= a_sh | {{(WIDTH-1){1'b0}}, 1'b1};
                    end else begin
                        p <= p_sh[WIDTH-1:0];
                        a <= a_sh;
                    end
                    count <= count + 1'b1;
                end
                S_FIX: begin
                    q_r <= qneg ? -a : a;
                    r_r <= rneg ? -p : p;
                end
                default: ;
            endcase
        end
    end

    assign bus.quotient  = q_r;
    assign bus.remainder = r_r;
    assign bus.bval      = b_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.div_zero  = dz_r;
    assign bus.ovf       = ovf_r;
endmodule

// File: tb/tb_signed_divider_seq.sv
// tb/tb_signed_divider_seq.sv - randomized self-checking bench for signed_divider_seq
module tb_signed_divider_seq;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    signed_divider_seq_if #(.WIDTH(8)) bus ();

    signed_divider_seq #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_b(input logic [7:0] v);
        @(negedge clk);
        bus.sw     = v;
        bus.load_b = 1'b1;
        @(negedge clk);
        bus.load_b = 1'b0;
        check("bval_load", 32'(bus.bval), 32'(v));
    endtask

    // Reference: plain integer division truncates toward zero, remainder follows dividend sign.
    task automatic run_op(input logic [7:0] d, input logic [7:0] b, input int hold, input bit disturb);
        int sa, sb, lat, exp_lat;
        logic [7:0] eq, er;
        logic edz, eov;
        sa = $signed(d);
        sb = $signed(b);
        if (sb == 0) begin
            eq = 8'h00; er = d; edz = 1'b1; eov = 1'b0; exp_lat = 2;
        end else if (sa == -128 && sb == -1) begin
            eq = 8'h80; er = 8'h00; edz = 1'b0; eov = 1'b1; exp_lat = 2;
        end else begin
            eq = 8'(sa / sb); er = 8'(sa % sb); edz = 1'b0; eov = 1'b0; exp_lat = 11;
        end
        @(negedge clk);
        bus.sw  = d;
        bus.run = 1'b1;
        lat = 0;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (e == 1) check("busy_after_start", 32'(bus.busy), 32'd1);
            if (bus.done) begin
                lat = e;
                break;
            end
            if (disturb) begin
                bus.load_b = (e < 6);
                bus.clear  = (e < 6);
                bus.sw     = 8'($urandom);
            end
        end
        bus.load_b = 1'b0;
        bus.clear  = 1'b0;
        check("done_latency", 32'(lat), 32'(exp_lat));
        check("quotient", 32'(bus.quotient), 32'(eq));
        check("remainder", 32'(bus.remainder), 32'(er));
        check("div_zero", 32'(bus.div_zero), 32'(edz));
        check("ovf", 32'(bus.ovf), 32'(eov));
        check("bval_kept", 32'(bus.bval), 32'(b));
        check("busy_in_done", 32'(bus.busy), 32'd0);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            @(negedge clk);
            check("hold_done", 32'(bus.done), 32'd1);
            check("hold_no_restart", 32'(bus.busy), 32'd0);
            check("hold_quotient", 32'(bus.quotient), 32'(eq));
        end
        bus.run = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("done_cleared", 32'(bus.done), 32'd0);
        check("quotient_retained", 32'(bus.quotient), 32'(eq));
        check("remainder_retained", 32'(bus.remainder), 32'(er));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_quotient"}, 32'(bus.quotient), 32'd0);
        check({tag, "_remainder"}, 32'(bus.remainder), 32'd0);
        check({tag, "_bval"}, 32'(bus.bval), 32'd0);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_done"}, 32'(bus.done), 32'd0);
        check({tag, "_div_zero"}, 32'(bus.div_zero), 32'd0);
        check({tag, "_ovf"}, 32'(bus.ovf), 32'd0);
    endtask

    initial begin
        logic [7:0] rb, rd;
        rst        = 1'b1;
        bus.sw     = 8'h00;
        bus.load_b = 1'b0;
        bus.clear  = 1'b0;
        bus.run    = 1'b0;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        load_b(8'hC5); run_op(8'h07, 8'hC5, 0, 1'b0);
        load_b(8'h07); run_op(8'hC5, 8'h07, 0, 1'b0);
        load_b(8'hF9); run_op(8'h3B, 8'hF9, 0, 1'b0);
        load_b(8'hFF); run_op(8'h80, 8'hFF, 0, 1'b0);
        load_b(8'h74); run_op(8'h74, 8'h74, 0, 1'b0);
        load_b(8'h00); run_op(8'h64, 8'h00, 0, 1'b0);

        // Asynchronous reset while the iteration counter sits at 4.
        load_b(8'h07);
        @(negedge clk);
        bus.sw  = 8'd59;
        bus.run = 1'b1;
        repeat (6) @(posedge clk);
        #2 rst = 1'b1;
        #1 check_all_zero("async_reset");
        @(negedge clk);
        rst     = 1'b0;
        bus.run = 1'b0;
        load_b(8'h07); run_op(8'd59, 8'h07, 0, 1'b0);

        @(negedge clk);
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        check("clear_quotient", 32'(bus.quotient), 32'd0);
        check("clear_remainder", 32'(bus.remainder), 32'd0);

        load_b(8'hF3); run_op(8'h65, 8'hF3, 20, 1'b1);
        load_b(8'h7F); run_op(8'h81, 8'h7F, 0, 1'b1);

        for (int i = 0; i < 30; i++) begin
            rb = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            rd = ($urandom_range(0, 5) == 0) ? 8'h80 : 8'($urandom);
            if ($urandom_range(0, 9) == 0) rb = 8'hFF;
            load_b(rb);
            run_op(rd, rb, 0, 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
